// File: rtl/rambus_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of a single shared RAM bus.
// Granted requester is passed through combinationally; stalled accesses abort with err after TIMEOUT cycles.
module rambus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,

   input  logic        m0_wb_cyc_i,
   input  logic        m0_wb_stb_i,
   input  logic        m0_wb_we_i,
   input  logic [3:0]  m0_wb_sel_i,
   input  logic [31:0] m0_wb_dat_i,
   input  logic [7:0]  m0_wb_adr_i,
   output logic        m0_wb_ack_o,
   output logic        m0_wb_err_o,
   output logic [31:0] m0_wb_dat_o,

   input  logic        m1_wb_cyc_i,
   input  logic        m1_wb_stb_i,
   input  logic        m1_wb_we_i,
   input  logic [3:0]  m1_wb_sel_i,
   input  logic [31:0] m1_wb_dat_i,
   input  logic [7:0]  m1_wb_adr_i,
   output logic        m1_wb_ack_o,
   output logic        m1_wb_err_o,
   output logic [31:0] m1_wb_dat_o,

   output logic        rambus_wb_clk_o,
   output logic        rambus_wb_rst_o,
   output logic        rambus_wb_cyc_o,
   output logic        rambus_wb_stb_o,
   output logic        rambus_wb_we_o,
   output logic [3:0]  rambus_wb_sel_o,
   output logic [31:0] rambus_wb_dat_o,
   output logic [9:0]  rambus_wb_adr_o,
   input  logic        rambus_wb_ack_i,
   input  logic [31:0] rambus_wb_dat_i
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state, state_nxt;
   logic          grant, grant_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] count, count_nxt;

   logic          req0, req1;
   logic          g_cyc, g_stb, g_we;
   logic [3:0]    g_sel;
   logic [31:0]   g_dat;
   logic [7:0]    g_adr;

   assign rambus_wb_clk_o = wb_clk_i;
   assign rambus_wb_rst_o = wb_rst_i;
   assign m0_wb_dat_o     = rambus_wb_dat_i;
   assign m1_wb_dat_o     = rambus_wb_dat_i;

   assign req0  = m0_wb_cyc_i & m0_wb_stb_i;
   assign req1  = m1_wb_cyc_i & m1_wb_stb_i;

   assign g_cyc = grant ? m1_wb_cyc_i : m0_wb_cyc_i;
   assign g_stb = grant ? m1_wb_stb_i : m0_wb_stb_i;
   assign g_we  = grant ? m1_wb_we_i  : m0_wb_we_i;
   assign g_sel = grant ? m1_wb_sel_i : m0_wb_sel_i;
   assign g_dat = grant ? m1_wb_dat_i : m0_wb_dat_i;
   assign g_adr = grant ? m1_wb_adr_i : m0_wb_adr_i;

   // last starts at 1 so requester 0 wins the first tie after reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
         count <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
         count <= count_nxt;
      end
   end

   // Outputs are held at 0 while reset is high so an in-flight access leaks no ack or err
   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      last_nxt        = last;
      count_nxt       = count;
      rambus_wb_cyc_o = 1'b0;
      rambus_wb_stb_o = 1'b0;
      rambus_wb_we_o  = 1'b0;
      rambus_wb_sel_o = 4'h0;
      rambus_wb_dat_o = 32'h0;
      rambus_wb_adr_o = 10'h0;
      m0_wb_ack_o     = 1'b0;
      m1_wb_ack_o     = 1'b0;
      m0_wb_err_o     = 1'b0;
      m1_wb_err_o     = 1'b0;

      if (!wb_rst_i) begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  grant_nxt = (req0 & req1) ? ~last : req1;
                  state_nxt = BUSY;
                  count_nxt = '0;
               end
            end
            BUSY: begin
               if (!g_cyc) begin
                  state_nxt = IDLE;
                  last_nxt  = grant;
               end else begin
                  rambus_wb_cyc_o = 1'b1;
                  rambus_wb_stb_o = g_stb;
                  rambus_wb_we_o  = g_we;
                  rambus_wb_sel_o = g_sel;
                  rambus_wb_dat_o = g_dat;
                  rambus_wb_adr_o = {g_adr, 2'b00};
                  // ack is checked before the timeout so a coincident ack completes normally
                  if (rambus_wb_ack_i) begin
                     m0_wb_ack_o = ~grant;
                     m1_wb_ack_o = grant;
                     state_nxt   = IDLE;
                     last_nxt    = grant;
                  end else if (count == CNT_MAX) begin
                     rambus_wb_cyc_o = 1'b0;
                     rambus_wb_stb_o = 1'b0;
                     m0_wb_err_o     = ~grant;
                     m1_wb_err_o     = grant;
                     state_nxt       = IDLE;
                     last_nxt        = grant;
                  end else begin
                     count_nxt = count + CW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Bench for rambus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_rambus_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [3:0]  m_sel [2];
   logic [31:0] m_dat [2];
   logic [7:0]  m_adr [2];
   logic        ram_ack;
   logic [31:0] ram_dat;

   logic        ack0, ack1, err0, err1;
   logic [31:0] dat0, dat1;
   logic        r_clk, r_rst, r_cyc, r_stb, r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_dat;
   logic [9:0]  r_adr;

   int tests_run    = 0;
   int tests_failed = 0;
   bit cmp_en       = 1'b0;
   int ack0_count   = 0;
   int ack0_base;

   // Model: an access belongs to one owner and ends on ack, abort (cyc dropped) or after TO+1 waiting cycles
   bit          mdl_busy   = 1'b0;
   int          mdl_owner  = 0;
   int          mdl_last   = 1;
   int          mdl_waited = 0;

   logic        e_cyc, e_stb, e_we;
   logic [3:0]  e_sel;
   logic [31:0] e_dat;
   logic [9:0]  e_adr;
   logic [1:0]  e_ack, e_err;
   logic        expired;

   rambus_arbiter #(.TIMEOUT(TO)) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .m0_wb_cyc_i     (m_cyc[0]),
      .m0_wb_stb_i     (m_stb[0]),
      .m0_wb_we_i      (m_we[0]),
      .m0_wb_sel_i     (m_sel[0]),
      .m0_wb_dat_i     (m_dat[0]),
      .m0_wb_adr_i     (m_adr[0]),
      .m0_wb_ack_o     (ack0),
      .m0_wb_err_o     (err0),
      .m0_wb_dat_o     (dat0),
      .m1_wb_cyc_i     (m_cyc[1]),
      .m1_wb_stb_i     (m_stb[1]),
      .m1_wb_we_i      (m_we[1]),
      .m1_wb_sel_i     (m_sel[1]),
      .m1_wb_dat_i     (m_dat[1]),
      .m1_wb_adr_i     (m_adr[1]),
      .m1_wb_ack_o     (ack1),
      .m1_wb_err_o     (err1),
      .m1_wb_dat_o     (dat1),
      .rambus_wb_clk_o (r_clk),
      .rambus_wb_rst_o (r_rst),
      .rambus_wb_cyc_o (r_cyc),
      .rambus_wb_stb_o (r_stb),
      .rambus_wb_we_o  (r_we),
      .rambus_wb_sel_o (r_sel),
      .rambus_wb_dat_o (r_dat),
      .rambus_wb_adr_o (r_adr),
      .rambus_wb_ack_i (ram_ack),
      .rambus_wb_dat_i (ram_dat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int idx, input logic cyc, input logic stb, input logic we,
                                 input logic [3:0] sel, input logic [31:0] dat, input logic [7:0] adr);
      m_cyc[idx] = cyc;
      m_stb[idx] = stb;
      m_we[idx]  = we;
      m_sel[idx] = sel;
      m_dat[idx] = dat;
      m_adr[idx] = adr;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mdl_busy   = 1'b0;
         mdl_last   = 1;
         mdl_waited = 0;
      end else if (!mdl_busy) begin
         if ((m_cyc[0] & m_stb[0]) || (m_cyc[1] & m_stb[1])) begin
            if ((m_cyc[0] & m_stb[0]) && (m_cyc[1] & m_stb[1]))
               mdl_owner = 1 - mdl_last;
            else
               mdl_owner = (m_cyc[1] & m_stb[1]) ? 1 : 0;
            mdl_busy   = 1'b1;
            mdl_waited = 0;
         end
      end else if (!m_cyc[mdl_owner] || ram_ack || mdl_waited == TO) begin
         mdl_busy = 1'b0;
         mdl_last = mdl_owner;
      end else begin
         mdl_waited++;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
         e_sel = 4'h0; e_dat = 32'h0; e_adr = 10'h0;
         e_ack = 2'b00; e_err = 2'b00;
         expired = 1'b0;
         if (!rst && mdl_busy && m_cyc[mdl_owner]) begin
            expired = !ram_ack && (mdl_waited == TO);
            e_cyc   = !expired;
            e_stb   = m_stb[mdl_owner] && !expired;
            e_we    = m_we[mdl_owner];
            e_sel   = m_sel[mdl_owner];
            e_dat   = m_dat[mdl_owner];
            e_adr   = 10'(m_adr[mdl_owner]) * 10'd4;
            if (ram_ack)      e_ack[mdl_owner] = 1'b1;
            else if (expired) e_err[mdl_owner] = 1'b1;
         end
         check_output("rambus_cyc", 64'(r_cyc), 64'(e_cyc));
         check_output("rambus_stb", 64'(r_stb), 64'(e_stb));
         check_output("rambus_we",  64'(r_we),  64'(e_we));
         check_output("rambus_sel", 64'(r_sel), 64'(e_sel));
         check_output("rambus_dat", 64'(r_dat), 64'(e_dat));
         check_output("rambus_adr", 64'(r_adr), 64'(e_adr));
         check_output("m0_ack",     64'(ack0),  64'(e_ack[0]));
         check_output("m1_ack",     64'(ack1),  64'(e_ack[1]));
         check_output("m0_err",     64'(err0),  64'(e_err[0]));
         check_output("m1_err",     64'(err1),  64'(e_err[1]));
         check_output("m0_dat_o",   64'(dat0),  64'(ram_dat));
         check_output("m1_dat_o",   64'(dat1),  64'(ram_dat));
         check_output("rambus_rst", 64'(r_rst), 64'(rst));
         check_output("rambus_clk", 64'(r_clk), 64'(clk));
         if (ack0) ack0_count++;
      end
   end

   initial begin
      rst     = 1'b1;
      ram_ack = 1'b0;
      ram_dat = 32'h0;
      m_cyc   = 2'b00;
      m_stb   = 2'b00;
      m_we    = 2'b00;
      for (int i = 0; i < 2; i++) begin
         m_sel[i] = 4'h0;
         m_dat[i] = 32'h0;
         m_adr[i] = 8'h0;
      end
      tick();
      tick();
      cmp_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);
      check_output("reset_cyc", 64'(r_cyc), 64'h0);
      check_output("reset_adr", 64'(r_adr), 64'h0);
      check_output("reset_ack", 64'({ack1, ack0}), 64'h0);
      check_output("reset_err", 64'({err1, err0}), 64'h0);

      // m0 write, RAM acks after two wait cycles
      tick();
      ack0_base = ack0_count;
      apply_stimulus(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 8'h05);
      tick();
      @(negedge clk);
      check_output("wr_adr", 64'(r_adr), 64'h014);
      check_output("wr_we",  64'(r_we),  64'h1);
      check_output("wr_dat", 64'(r_dat), 64'hDEADBEEF);
      tick();
      tick();
      ram_ack = 1'b1;
      @(negedge clk);
      check_output("wr_ack", 64'(ack0), 64'h1);
      tick();
      ram_ack = 1'b0;
      apply_stimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();
      tick();
      check_output("wr_ack_pulses", 64'(ack0_count - ack0_base), 64'h1);

      // m1 read of the top word
      ram_dat = 32'h12345678;
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 8'hFF);
      tick();
      @(negedge clk);
      check_output("rd_adr", 64'(r_adr), 64'h3FC);
      check_output("rd_we",  64'(r_we),  64'h0);
      tick();
      ram_ack = 1'b1;
      @(negedge clk);
      check_output("rd_dat",  64'(dat1), 64'h12345678);
      check_output("rd_ack1", 64'(ack1), 64'h1);
      check_output("rd_ack0", 64'(ack0), 64'h0);
      tick();
      ram_ack = 1'b0;
      apply_stimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();

      // timeout on m0 with m1 waiting behind it
      apply_stimulus(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hA5A5A5A5, 8'h20);
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 8'h10);
      for (int i = 1; i <= 5; i++) begin
         tick();
         @(negedge clk);
         if (i == 5) begin
            check_output("to_err0", 64'(err0),  64'h1);
            check_output("to_err1", 64'(err1),  64'h0);
            check_output("to_cyc",  64'(r_cyc), 64'h0);
         end else begin
            check_output("to_wait_err0", 64'(err0), 64'h0);
         end
      end
      tick();
      @(negedge clk);
      check_output("to_bubble", 64'(r_cyc), 64'h0);
      tick();
      ram_ack = 1'b1;
      @(negedge clk);
      check_output("to_next_adr",  64'(r_adr), 64'h040);
      check_output("to_next_ack1", 64'(ack1),  64'h1);
      tick();
      ram_ack = 1'b0;
      apply_stimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      apply_stimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();

      // pass-through of changing data, then m1 drops cyc mid-access
      apply_stimulus(1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h11111111, 8'h01);
      tick();
      @(negedge clk);
      check_output("pt_dat_a", 64'(r_dat), 64'h11111111);
      check_output("pt_sel",   64'(r_sel), 64'h3);
      tick();
      m_dat[1] = 32'h22222222;
      @(negedge clk);
      check_output("pt_dat_b", 64'(r_dat), 64'h22222222);
      tick();
      m_cyc[1] = 1'b0;
      @(negedge clk);
      check_output("drop_cyc", 64'(r_cyc), 64'h0);
      check_output("drop_ack", 64'(ack1),  64'h0);
      check_output("drop_err", 64'(err1),  64'h0);
      tick();
      apply_stimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();

      // reset in the middle of an m1 access, then both request continuously
      apply_stimulus(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 8'h02);
      tick();
      @(negedge clk);
      check_output("mid_cyc", 64'(r_cyc), 64'h1);
      check_output("mid_adr", 64'(r_adr), 64'h008);
      tick();
      rst     = 1'b1;
      ram_ack = 1'b1;
      apply_stimulus(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 8'h03);
      @(negedge clk);
      check_output("rst_cyc", 64'(r_cyc), 64'h0);
      check_output("rst_adr", 64'(r_adr), 64'h0);
      check_output("rst_ack", 64'({ack1, ack0}), 64'h0);
      check_output("rst_err", 64'({err1, err0}), 64'h0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("rr_cyc",  64'(r_cyc), 64'(i % 2));
         check_output("rr_ack0", 64'(ack0),  64'(i == 1 || i == 5));
         check_output("rr_ack1", 64'(ack1),  64'(i == 3 || i == 7));
         tick();
      end
      ram_ack = 1'b0;
      apply_stimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      apply_stimulus(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();

      // ack arrives in the same cycle the wait count reaches TO
      apply_stimulus(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 8'h07);
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 5) ram_ack = 1'b1;
         @(negedge clk);
         if (i == 5) begin
            check_output("co_ack0", 64'(ack0),  64'h1);
            check_output("co_err0", 64'(err0),  64'h0);
            check_output("co_cyc",  64'(r_cyc), 64'h1);
         end
      end
      tick();
      ram_ack = 1'b0;
      apply_stimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rambus_arbiter.md
RAMBUS_ARBITER -- requirements
Module: rambus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of BUSY cycles to wait for rambus_wb_ack_i before an access is aborted.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 mN_wb_cyc_i, mN_wb_stb_i, mN_wb_we_i (N=0,1)  input  1 each  requester N Wishbone cycle, strobe and write enable.
REQ-005 mN_wb_sel_i  input  4  requester N byte select.
REQ-006 mN_wb_dat_i  input  32  requester N write data.
REQ-007 mN_wb_adr_i  input  8  requester N word address.
REQ-008 mN_wb_ack_o  output  1  requester N access-complete strobe.
REQ-009 mN_wb_err_o  output  1  requester N timeout-abort strobe.
REQ-010 mN_wb_dat_o  output  32  requester N read data.
REQ-011 rambus_wb_clk_o, rambus_wb_rst_o  output  1 each  shared-RAM clock and reset.
REQ-012 rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o  output  1 each  shared-RAM cycle, strobe and write enable.
REQ-013 rambus_wb_sel_o  output  4  shared-RAM byte select.
REQ-014 rambus_wb_dat_o  output  32  shared-RAM write data.
REQ-015 rambus_wb_adr_o  output  10  shared-RAM byte address.
REQ-016 rambus_wb_ack_i  input  1  shared-RAM acknowledge.
REQ-017 rambus_wb_dat_i  input  32  shared-RAM read data.

Function
REQ-018 rambus_wb_clk_o SHALL equal wb_clk_i; rambus_wb_rst_o SHALL equal wb_rst_i (both combinational).
REQ-019 FSM states SHALL be IDLE and BUSY; registers SHALL be grant (1 bit), last (1 bit) and a timeout counter of width clog2(TIMEOUT+1).
REQ-020 Request SHALL be reqN = mN_wb_cyc_i & mN_wb_stb_i.
REQ-021 IDLE: if exactly one reqN is asserted, grant SHALL load N; if both are asserted, grant SHALL load !last (round-robin); state SHALL become BUSY; counter SHALL clear.
REQ-022 IDLE: all rambus_wb_cyc/stb/we/sel/dat/adr outputs SHALL be 0.
REQ-023 BUSY: rambus_wb_cyc_o/stb_o/we_o/sel_o/dat_o SHALL equal the granted requester's inputs combinationally; rambus_wb_adr_o SHALL equal {m<grant>_wb_adr_i, 2'b00}.
REQ-024 BUSY: m<grant>_wb_ack_o SHALL equal rambus_wb_ack_i combinationally; the non-granted requester's ack_o SHALL be 0.
REQ-025 mN_wb_dat_o SHALL equal rambus_wb_dat_i at all times; it is valid only while mN_wb_ack_o is high.
REQ-026 BUSY with rambus_wb_ack_i=1: state SHALL return to IDLE and last SHALL load grant; a new grant SHALL be issued no earlier than the following IDLE cycle (one idle bubble per access).
REQ-027 BUSY, ack low, counter < TIMEOUT: counter SHALL increment by 1.
REQ-028 BUSY, ack low, counter == TIMEOUT: m<grant>_wb_err_o SHALL pulse high for that one cycle; rambus_wb_cyc_o/stb_o SHALL be forced to 0 in that cycle; state SHALL return to IDLE; last SHALL load grant.
REQ-029 BUSY and the granted requester deasserts cyc (ack low): rambus outputs SHALL drop to 0 in that cycle; state SHALL return to IDLE with no ack or err issued; last SHALL load grant.
REQ-030 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and err SHALL stay 0.
REQ-031 err_o SHALL be 0 for both requesters outside the REQ-028 cycle.
REQ-032 Input changes on the granted requester during BUSY SHALL pass through unchanged; the arbiter SHALL NOT latch request data.

Reset
REQ-033 While wb_rst_i=1 at a clock edge: state SHALL be IDLE, grant=0, last=1 (so requester 0 wins the first tie), and counter=0.
REQ-034 After reset, all ack_o, err_o and rambus cyc/stb/we/sel/dat/adr outputs SHALL read 0; reset asserted mid-BUSY SHALL abort the access with no ack or err.

Verification
REQ-035 m0 writes adr=8'h05, dat=32'hDEADBEEF, sel=4'hF; RAM acks after 2 cycles -> rambus_wb_adr_o=10'h014, rambus_wb_we_o=1, m0_wb_ack_o pulses exactly once.
REQ-036 m0 and m1 both request continuously from reset -> grants alternate 0,1,0,1 with one IDLE cycle between accesses.
REQ-037 m1 reads adr=8'hFF with RAM returning 32'h12345678 -> rambus_wb_adr_o=10'h3FC; m1_wb_dat_o=32'h12345678 while m1_wb_ack_o=1; m0_wb_ack_o stays 0.
REQ-038 TIMEOUT=4, RAM never acks -> m0_wb_err_o pulses on the 5th BUSY cycle; rambus_wb_cyc_o=0 in that cycle; the next pending m1 request is granted after it.
REQ-039 wb_rst_i asserted mid-access; ack and the counter reaching TIMEOUT coincide in a separate run -> on reset, all outputs are 0 and both requesters simultaneously then get m0 first; on the coincidence, ack=1 and err=0.
